mem_arbiter: RTL and testbench

//  Shares one single-port bram between instruction fetch (IF) and data_mov (D).

---
 rtl/mem_arb_pkg.sv | 21 ++
 rtl/mem_arb_rd_tracker.sv | 83 ++++++++
 rtl/mem_arbiter.sv | 97 +++++++++
 tb/tb_mem_arbiter.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types and helpers for the single-port memory arbiter.
package mem_arb_pkg;

    // Which requester a read belongs to.
    typedef enum logic {
        OWN_IF = 1'b0,
        OWN_D  = 1'b1
    } owner_e;

    // Read-tracking state.
    typedef enum logic {
        S_IDLE    = 1'b0,
        S_RD_WAIT = 1'b1
    } state_e;

    // Width of a down-counter that must hold the value rd_lat.
    function automatic int lat_w(input int rd_lat);
        return $clog2(rd_lat + 1);
    endfunction

endpackage

// File: rtl/mem_arb_rd_tracker.sv
// Read tracker: holds the state, latency down-counter and owner tag of
// the single read in flight, raises rvalid to the owner when the read
// data is due, and tells the arbiter when a new grant may be issued.
module mem_arb_rd_tracker
    import mem_arb_pkg::*;
#(
    parameter int RD_LAT = 1
) (
    input  logic   clk,
    input  logic   rst,
    input  logic   rd_start,
    input  owner_e rd_owner,
    output logic   arb_en,
    output logic   busy,
    output logic   if_rvalid,
    output logic   d_rvalid
);

    localparam int               CNT_W   = lat_w(RD_LAT);
    localparam logic [CNT_W-1:0] LAT_CNT = CNT_W'(RD_LAT);
    localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    owner_e           own_q, own_d;
    logic             rd_done;

    // State, counter and owner registers; any reset drops the read in flight.
    // NOTE: sequential state uses non-blocking (<=) so every register samples
    // pre-edge values regardless of process ordering.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            own_q   <= OWN_IF;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            own_q   <= own_d;
        end
    end

    // Next-state logic: load on read grant, count down, deliver at cnt==1.
    // NOTE: every signal assigned here gets a default first so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        own_d   = own_q;
        rd_done = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (rd_start) begin
                    state_d = S_RD_WAIT;
                    cnt_d   = LAT_CNT;
                    own_d   = rd_owner;
                end
            end
            S_RD_WAIT: begin
                if (cnt_q == ONE) begin
                    rd_done = 1'b1;
                    if (rd_start) begin
                        cnt_d = LAT_CNT;
                        own_d = rd_owner;
                    end else begin
                        state_d = S_IDLE;
                        cnt_d   = '0;
                    end
                end else begin
                    cnt_d = cnt_q - ONE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Arbitration window: idle, or the last wait cycle; closed while in reset.
    assign arb_en    = rst && ((state_q == S_IDLE) || (cnt_q == ONE));
    assign busy      = (state_q == S_RD_WAIT);
    assign if_rvalid = rd_done && (own_q == OWN_IF);
    assign d_rvalid  = rd_done && (own_q == OWN_D);

endmodule

// File: rtl/mem_arbiter.sv
// Shares one single-port bram between instruction fetch (IF) and data
// moves (D). One read in flight; reads return after RD_LAT cycles, tagged
// to the requester. Writes complete in their grant cycle.
// Optional feature: define MEM_ARB_RR_EN for round-robin arbitration on
// contention; otherwise D has fixed priority over IF.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int RD_LAT = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_gnt,
    output logic              if_rvalid,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_gnt,
    output logic              d_rvalid,
    output logic [DATA_W-1:0] d_rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_write,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy
);

    if (RD_LAT < 1 || RD_LAT > 4) begin : g_bad_rd_lat
        $error("mem_arbiter: RD_LAT must be in 1..4");
    end

    logic   arb_en;
    logic   d_wins;
    logic   rd_start;
    owner_e rd_owner;

`ifdef MEM_ARB_RR_EN
    owner_e last_gnt_q;

    // Remember the most recent winner so a contest goes to the other side.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            last_gnt_q <= OWN_IF;
        end else if (d_gnt) begin
            last_gnt_q <= OWN_D;
        end else if (if_gnt) begin
            last_gnt_q <= OWN_IF;
        end
    end

    assign d_wins = d_req && (!if_req || (last_gnt_q == OWN_IF));
`else
    assign d_wins = d_req;
`endif

    // Combinational grant and memory-port mux; idle port drives zeros.
    always_comb begin
        d_gnt     = arb_en && d_wins;
        if_gnt    = arb_en && if_req && !d_wins;
        mem_addr  = '0;
        mem_write = 1'b0;
        mem_wdata = '0;
        if (d_gnt) begin
            mem_addr  = d_addr;
            mem_write = d_we;
            mem_wdata = d_wdata;
        end else if (if_gnt) begin
            mem_addr  = if_addr;
        end
    end

    assign rd_start = if_gnt || (d_gnt && !d_we);
    assign rd_owner = d_gnt ? OWN_D : OWN_IF;

    mem_arb_rd_tracker #(
        .RD_LAT (RD_LAT)
    ) u_rd_tracker (
        .clk       (clk),
        .rst       (rst),
        .rd_start  (rd_start),
        .rd_owner  (rd_owner),
        .arb_en    (arb_en),
        .busy      (busy),
        .if_rvalid (if_rvalid),
        .d_rvalid  (d_rvalid)
    );

    assign if_rdata = if_rvalid ? mem_rdata : '0;
    assign d_rdata  = d_rvalid  ? mem_rdata : '0;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: three instances with RD_LAT = 1, 2, 3,
// each attached to its own behavioural bram of matching latency.
module tb_mem_arbiter;

    logic clk = 1'b0;
    logic rst;

    logic [2:0]  if_req, d_req, d_we;
    logic [2:0]  if_gnt, if_rvalid, d_gnt, d_rvalid, mem_write, busy;
    logic [31:0] if_addr [3];
    logic [31:0] d_addr [3];
    logic [31:0] d_wdata [3];
    logic [31:0] if_rdata [3];
    logic [31:0] d_rdata [3];
    logic [31:0] mem_addr [3];
    logic [31:0] mem_wdata [3];
    logic [31:0] mem_rdata [3];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        logic [31:0] mem  [0:255];
        logic [31:0] pipe [0:g];

        mem_arbiter #(
            .ADDR_W (32),
            .DATA_W (32),
            .RD_LAT (g + 1)
        ) u_dut (
            .clk       (clk),
            .rst       (rst),
            .if_req    (if_req[g]),
            .if_addr   (if_addr[g]),
            .if_gnt    (if_gnt[g]),
            .if_rvalid (if_rvalid[g]),
            .if_rdata  (if_rdata[g]),
            .d_req     (d_req[g]),
            .d_we      (d_we[g]),
            .d_addr    (d_addr[g]),
            .d_wdata   (d_wdata[g]),
            .d_gnt     (d_gnt[g]),
            .d_rvalid  (d_rvalid[g]),
            .d_rdata   (d_rdata[g]),
            .mem_addr  (mem_addr[g]),
            .mem_write (mem_write[g]),
            .mem_wdata (mem_wdata[g]),
            .mem_rdata (mem_rdata[g]),
            .busy      (busy[g])
        );

        // bram model: write on grant edge, read data after g+1 cycles
        always @(posedge clk) begin
            if (mem_write[g]) mem[mem_addr[g][7:0]] <= mem_wdata[g];
            pipe[0] <= mem[mem_addr[g][7:0]];
            for (int k = 1; k <= g; k++) pipe[k] <= pipe[k-1];
        end
        assign mem_rdata[g] = pipe[g];
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic mid();
        @(negedge clk);
    endtask

    task automatic cyc_end();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input int i, input logic [31:0] a, input logic [31:0] dv);
        d_req[i] = 1'b1; d_we[i] = 1'b1; d_addr[i] = a; d_wdata[i] = dv;
        mid();
        check($sformatf("wr%0d_gnt_%0h", i, a), 32'(d_gnt[i]), 32'd1);
        check($sformatf("wr%0d_write_%0h", i, a), 32'(mem_write[i]), 32'd1);
        cyc_end();
        d_req[i] = 1'b0; d_we[i] = 1'b0; d_wdata[i] = '0; d_addr[i] = '0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [3:0] exp_d;

        rst = 1'b0;
        if_req = '0; d_req = '0; d_we = '0;
        for (int i = 0; i < 3; i++) begin
            if_addr[i] = '0; d_addr[i] = '0; d_wdata[i] = '0;
        end

        // reset state
        mid();
        for (int i = 0; i < 3; i++) begin
            check($sformatf("rst_busy%0d", i), 32'(busy[i]), 32'd0);
            check($sformatf("rst_rvalid%0d", i), 32'({if_rvalid[i], d_rvalid[i]}), 32'd0);
            check($sformatf("rst_mem_addr%0d", i), mem_addr[i], 32'd0);
        end
        cyc_end();
        cyc_end();
        rst = 1'b1;
        cyc_end();

        // preload through the write path
        wr(0, 32'h10, 32'hA0);
        wr(0, 32'h11, 32'hA1);
        wr(1, 32'h40, 32'h77);
        wr(2, 32'h20, 32'hDEAD);

        // 1: back-to-back fetches, RD_LAT=1
        if_req[0] = 1'b1; if_addr[0] = 32'h10;
        mid();
        check("t1_gnt0", 32'(if_gnt[0]), 32'd1);
        check("t1_rvalid0", 32'(if_rvalid[0]), 32'd0);
        check("t1_addr0", mem_addr[0], 32'h10);
        cyc_end(); if_addr[0] = 32'h11;
        mid();
        check("t1_gnt1", 32'(if_gnt[0]), 32'd1);
        check("t1_rvalid1", 32'(if_rvalid[0]), 32'd1);
        check("t1_rdata1", if_rdata[0], 32'hA0);
        check("t1_busy1", 32'(busy[0]), 32'd1);
        check("t1_addr1", mem_addr[0], 32'h11);
        cyc_end(); if_addr[0] = 32'h12;
        mid();
        check("t1_gnt2", 32'(if_gnt[0]), 32'd1);
        check("t1_rdata2", if_rdata[0], 32'hA1);
        cyc_end(); if_req[0] = 1'b0;
        mid();
        check("t1_gnt3", 32'(if_gnt[0]), 32'd0);
        check("t1_rvalid3", 32'(if_rvalid[0]), 32'd1);
        cyc_end();
        mid();
        check("t1_busy_end", 32'(busy[0]), 32'd0);
        check("t1_rvalid_end", 32'(if_rvalid[0]), 32'd0);
        cyc_end();

        // 2: RD_LAT=3 data read while fetch waits
        d_req[2] = 1'b1; d_addr[2] = 32'h20; if_addr[2] = 32'h10;
        mid();
        check("t2_dgnt_T", 32'(d_gnt[2]), 32'd1);
        check("t2_addr_T", mem_addr[2], 32'h20);
        check("t2_write_T", 32'(mem_write[2]), 32'd0);
        cyc_end(); d_req[2] = 1'b0; if_req[2] = 1'b1;
        for (int k = 1; k <= 2; k++) begin
            mid();
            check($sformatf("t2_gnt_T%0d", k), 32'({if_gnt[2], d_gnt[2]}), 32'd0);
            check($sformatf("t2_rvalid_T%0d", k), 32'(d_rvalid[2]), 32'd0);
            check($sformatf("t2_busy_T%0d", k), 32'(busy[2]), 32'd1);
            cyc_end();
        end
        mid();
        check("t2_rvalid_T3", 32'(d_rvalid[2]), 32'd1);
        check("t2_rdata_T3", d_rdata[2], 32'hDEAD);
        check("t2_ifgnt_T3", 32'(if_gnt[2]), 32'd1);
        check("t2_addr_T3", mem_addr[2], 32'h10);
        cyc_end(); if_req[2] = 1'b0;
        for (int k = 0; k < 4; k++) cyc_end();

        // 3: write contends with fetch, then read-back
        d_req[0] = 1'b1; d_we[0] = 1'b1; d_addr[0] = 32'h30; d_wdata[0] = 32'h55;
        if_req[0] = 1'b1; if_addr[0] = 32'h10;
        mid();
        check("t3_dgnt", 32'(d_gnt[0]), 32'd1);
        check("t3_ifgnt", 32'(if_gnt[0]), 32'd0);
        check("t3_write", 32'(mem_write[0]), 32'd1);
        check("t3_addr", mem_addr[0], 32'h30);
        check("t3_wdata", mem_wdata[0], 32'h55);
        cyc_end(); d_req[0] = 1'b0; d_we[0] = 1'b0; d_wdata[0] = '0;
        mid();
        check("t3_ifgnt_next", 32'(if_gnt[0]), 32'd1);
        check("t3_write_next", 32'(mem_write[0]), 32'd0);
        cyc_end(); if_req[0] = 1'b0; d_req[0] = 1'b1;
        mid();
        check("t3_rb_gnt", 32'(d_gnt[0]), 32'd1);
        check("t3_if_rdata", if_rdata[0], 32'hA0);
        cyc_end(); d_req[0] = 1'b0;
        mid();
        check("t3_rb_rvalid", 32'(d_rvalid[0]), 32'd1);
        check("t3_rb_rdata", d_rdata[0], 32'h55);
        cyc_end();
        cyc_end();

        // 5: RD_LAT=2, reset in the cycle after the read grant
        if_req[1] = 1'b1; if_addr[1] = 32'h40;
        mid();
        check("t5_gnt", 32'(if_gnt[1]), 32'd1);
        cyc_end(); if_req[1] = 1'b0; rst = 1'b0;
        d_req[1] = 1'b1; d_addr[1] = 32'h40;
        for (int k = 0; k < 2; k++) begin
            mid();
            check($sformatf("t5_rst_busy%0d", k), 32'(busy[1]), 32'd0);
            check($sformatf("t5_rst_rvalid%0d", k), 32'({if_rvalid[1], d_rvalid[1]}), 32'd0);
            check($sformatf("t5_rst_gnt%0d", k), 32'({if_gnt[1], d_gnt[1]}), 32'd0);
            check($sformatf("t5_rst_addr%0d", k), mem_addr[1], 32'd0);
            check($sformatf("t5_rst_rdata%0d", k), if_rdata[1], 32'd0);
            cyc_end();
        end
        rst = 1'b1; d_req[1] = 1'b0;
        mid();
        check("t5_post_rvalid", 32'(if_rvalid[1]), 32'd0);
        check("t5_post_busy", 32'(busy[1]), 32'd0);
        cyc_end(); if_req[1] = 1'b1;
        mid();
        check("t5_new_gnt", 32'(if_gnt[1]), 32'd1);
        cyc_end(); if_req[1] = 1'b0;
        mid();
        check("t5_new_wait", 32'(if_rvalid[1]), 32'd0);
        cyc_end();
        mid();
        check("t5_new_rvalid", 32'(if_rvalid[1]), 32'd1);
        check("t5_new_rdata", if_rdata[1], 32'h77);
        cyc_end();

        // 4: both requesters held for four arbitration cycles (RD_LAT=1)
`ifdef MEM_ARB_RR_EN
        exp_d = 4'b0101;
`else
        exp_d = 4'b1111;
`endif
        if_req[0] = 1'b1; if_addr[0] = 32'h10;
        d_req[0] = 1'b1; d_we[0] = 1'b0; d_addr[0] = 32'h11;
        for (int c = 0; c < 4; c++) begin
            mid();
            check($sformatf("t4_dgnt%0d", c), 32'(d_gnt[0]), 32'(exp_d[c]));
            check($sformatf("t4_ifgnt%0d", c), 32'(if_gnt[0]), 32'(!exp_d[c]));
            if (c > 0) begin
                check($sformatf("t4_drv%0d", c), 32'(d_rvalid[0]), 32'(exp_d[c-1]));
                if (exp_d[c-1]) check($sformatf("t4_drd%0d", c), d_rdata[0], 32'hA1);
                else            check($sformatf("t4_ifrd%0d", c), if_rdata[0], 32'hA0);
            end
            cyc_end();
        end
        if_req[0] = 1'b0; d_req[0] = 1'b0;
        cyc_end();
        cyc_end();

        // 6: fetch raised and withdrawn during RD_WAIT (RD_LAT=3)
        d_req[2] = 1'b1; d_addr[2] = 32'h20;
        mid();
        check("t6_dgnt", 32'(d_gnt[2]), 32'd1);
        cyc_end(); d_req[2] = 1'b0; if_req[2] = 1'b1; if_addr[2] = 32'h20;
        mid();
        check("t6_ifgnt1", 32'(if_gnt[2]), 32'd0);
        cyc_end(); if_req[2] = 1'b0;
        mid();
        check("t6_ifgnt2", 32'(if_gnt[2]), 32'd0);
        cyc_end();
        mid();
        check("t6_drv", 32'(d_rvalid[2]), 32'd1);
        check("t6_drd", d_rdata[2], 32'hDEAD);
        check("t6_ifgnt3", 32'(if_gnt[2]), 32'd0);
        check("t6_ifrv3", 32'(if_rvalid[2]), 32'd0);
        cyc_end();
        mid();
        check("t6_ifrv4", 32'(if_rvalid[2]), 32'd0);
        check("t6_busy4", 32'(busy[2]), 32'd0);
        cyc_end();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
